// File: rtl/bank_response_merger.sv
// Merges read responses from NB word-interleaved banks into one valid/ready stream,
// rebuilding global addresses as {local_addr, bank} behind per-bank FIFOs and a round-robin arbiter.

module bank_rsp_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         ready,
  output logic         nonempty,
  output logic [W-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ready    = (cnt != CW'(DEPTH));
  assign nonempty = (cnt != '0);
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module bank_response_merger #(
  parameter int ADDR_W = 10,
  parameter int NB     = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int BANK_BITS = $clog2(NB)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NB-1:0]          bank_rsp_valid,
  output logic [NB-1:0]          bank_rsp_ready,
  input  logic [NB*ADDR_W-1:0]   bank_rsp_local_addr,
  input  logic [NB*DATA_W-1:0]   bank_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_global_addr,
  output logic [DATA_W-1:0]      out_data,
  output logic [BANK_BITS-1:0]   out_bank,
  output logic                   out_addr_err
);
  localparam int EW = ADDR_W + DATA_W;

  logic [NB-1:0]          push, pop, nonempty;
  logic [NB-1:0][EW-1:0]  head;
  logic [BANK_BITS-1:0]   rr_ptr, grant, idx;
  logic                   found, load;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_data;

  genvar g;
  generate
    for (g = 0; g < NB; g++) begin : g_bank
      assign push[g] = bank_rsp_valid[g] && bank_rsp_ready[g];
      bank_rsp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push[g]),
        .din      ({bank_rsp_local_addr[g*ADDR_W +: ADDR_W], bank_rsp_data[g*DATA_W +: DATA_W]}),
        .pop      (pop[g]),
        .ready    (bank_rsp_ready[g]),
        .nonempty (nonempty[g]),
        .dout     (head[g])
      );
    end
  endgenerate

  // First non-empty bank at or after rr_ptr; index arithmetic wraps since NB is a power of two.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = '0;
    for (int i = 0; i < NB; i++) begin
      idx = rr_ptr + BANK_BITS'(i);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign load     = !out_valid || out_ready;
  assign pop      = (load && found) ? (NB'(1) << grant) : '0;
  assign sel_addr = head[grant][DATA_W +: ADDR_W];
  assign sel_data = head[grant][DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      out_valid       <= 1'b0;
      out_global_addr <= '0;
      out_data        <= '0;
      out_bank        <= '0;
      out_addr_err    <= 1'b0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_global_addr <= {sel_addr[ADDR_W-BANK_BITS-1:0], grant};
        out_data        <= sel_data;
        out_bank        <= grant;
        out_addr_err    <= |sel_addr[ADDR_W-1 -: BANK_BITS];
        rr_ptr          <= grant + BANK_BITS'(1);
      end
    end
  end
endmodule

// File: doc/bank_response_merger.md
# bank_response_merger

Return-path counterpart to the global-to-bank address translation. Collects read responses from `NB` word-interleaved memory banks, each tagged with its intra-bank local address. Rebuilds the global address as `(local_addr << BANK_BITS) | bank`. Merges all banks into one valid/ready output stream through per-bank buffers and a round-robin arbiter, sitting between the bank array and the requesting engine.

## Interface
- `ADDR_W`, 10, global and local address width
- `NB`, 4, number of banks; power of two, ≥ 2
- `DATA_W`, 16, response data width
- `DEPTH`, 2, entries per bank buffer; ≥ 1
- `BANK_BITS`, `$clog2(NB)` (derived localparam), bank index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `bank_rsp_valid`  in  NB  per-bank response valid
- `bank_rsp_ready`  out  NB  per-bank accept
- `bank_rsp_local_addr`  in  NB*ADDR_W  bank b at bits [b*ADDR_W +: ADDR_W]
- `bank_rsp_data`  in  NB*DATA_W  bank b at bits [b*DATA_W +: DATA_W]
- `out_valid`  out  1  merged beat valid
- `out_ready`  in  1  consumer accept
- `out_global_addr`  out  ADDR_W  reconstructed global address
- `out_data`  out  DATA_W  response data
- `out_bank`  out  BANK_BITS  source bank index
- `out_addr_err`  out  1  beat's local address had nonzero bits in [ADDR_W-1 : ADDR_W-BANK_BITS]

## Operation
- Per-bank FIFO of `DEPTH` entries storing {local_addr, data}.
- Pointers wrap modulo `DEPTH`; a count per bank runs 0..DEPTH.
- `bank_rsp_ready[b] = (count[b] != DEPTH)`. It depends on registered state only, with no combinational path from `out_ready`.
- Push on bank b when `bank_rsp_valid[b] && bank_rsp_ready[b]`.
- Output register update condition: `load = !out_valid || out_ready`.
- When `load` is high and any FIFO is non-empty, the arbiter grants the first non-empty bank searching `rr_ptr, rr_ptr+1, …` mod NB.
  - That FIFO is popped and the output register is loaded.
  - `rr_ptr` becomes `grant+1` mod NB.
- When `load` is high and all FIFOs are empty, `out_valid` goes to 0.
- When `load` is low, the output register and `rr_ptr` hold.
- Reconstruction: `out_global_addr = {local_addr[ADDR_W-BANK_BITS-1:0], grant[BANK_BITS-1:0]}`. The upper `BANK_BITS` local bits are dropped.
- `out_addr_err = |local_addr[ADDR_W-1:ADDR_W-BANK_BITS]`. It is flagged per beat and does not block the beat.
- Push and pop on the same bank in the same cycle leave the count unchanged.
- Push is impossible when full, so no overflow exists and no beats are lost.

## Timing
- Reset (`rst` high at an edge):
  - FIFO counts and pointers = 0; `rr_ptr` = 0.
  - `out_valid` = 0; `out_global_addr`, `out_data`, `out_bank`, `out_addr_err` = 0.
  - `bank_rsp_ready` = all ones from the first cycle after reset.
  - Reset mid-operation discards all buffered and output beats.
- Latency: a beat pushed at edge N can be presented at the earliest with `out_valid` high after edge N+1 (two cycles, valid-in to valid-out). There is no input-to-output bypass.
- Throughput: one beat per cycle while `out_ready` is held high.
- `out_valid` and its payload stay stable while `out_valid && !out_ready`.
- Beats from one bank leave in arrival order. No ordering is guaranteed across banks.
- Fairness: with all banks continuously non-empty and `out_ready` = 1, grants cycle 0,1,…,NB-1 repeatedly.

## Test plan
- **Single beat:** reset, then bank 2 pushes local 5, data 0xABCD at edge N → `out_valid` high after edge N+1 with global 22 (0x016), `out_bank` 2, `out_addr_err` 0. `out_valid` drops one cycle later with `out_ready` = 1.
- **Simultaneous arrival:** all 4 banks push in one cycle with local = bank index → outputs in bank order 0,1,2,3 with globals 0, 5, 10, 15 on consecutive cycles. `rr_ptr` ends at 0.
- **Backpressure:** `out_ready` = 0 for 6 cycles while bank 1 offers 4 beats →
  - `bank_rsp_ready[1]` deasserts once the FIFO holds 2 and the output register holds 1.
  - The held output is stable.
  - After release, all 4 beats appear in order with no loss or duplication.
- **Address error:** bank 3 pushes local 0x101 (ADDR_W = 10) → `out_global_addr` 0x007 (local[7:0] = 0x01, bank 3), `out_addr_err` 1.
- **Fairness under load:** banks 0 and 2 always valid, `out_ready` = 1 → output banks alternate 0,2,0,2… with no starvation over 100 beats.
- **Reset mid-stream:** assert `rst` with beats buffered and `out_valid` = 1 → next cycle `out_valid` = 0, all `bank_rsp_ready` = 1. No stale beats appear after reset is released.
